clk_switch_ctrl: RTL and testbench

Control stage that drives the `sel` input of the glitch-free clock mux. It runs on a free-running reference clock and monitors heartbeat toggles from both selectable clock sources. It accepts software switch requests through a ready/valid handshake and holds a settle window after every `sel` change. It rejects requests to a dead source and, optionally, fails over automatically when the selected source stops toggling.

---
 rtl/clk_switch_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_switch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk_switch_ctrl                                               |
// | Purpose  : Control stage that drives the select of a glitch-free clock   |
// |            mux. Runs on the reference clock, watches heartbeat toggles   |
// |            from both clock sources, serves ready/valid switch requests,  |
// |            holds a settle window after every select change, rejects      |
// |            switches to dead sources and optionally fails over.           |
// | Ports    : clock, reset      reference clock, async active-high reset    |
// |            hb_a, hb_b        asynchronous heartbeat toggles per source   |
// |            req_valid/req_src/req_ready  switch request handshake         |
// |            sel               registered mux select (0 = A, 1 = B)        |
// |            switching         high during the settle window               |
// |            done/err/failover one-cycle status pulses                     |
// |            alive_a, alive_b  source health flags                         |
// | Config   : define CLK_SWITCH_AUTO_FAILOVER_EN to enable automatic        |
// |            failover when the selected source stops toggling.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module clk_switch_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int SETTLE  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic hb_a,
  input  logic hb_b,
  input  logic req_valid,
  input  logic req_src,
  output logic req_ready,
  output logic sel,
  output logic switching,
  output logic done,
  output logic err,
  output logic failover,
  output logic alive_a,
  output logic alive_b
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int ST_W = $clog2(SETTLE + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(SETTLE - 1);

  // Index 0 = source A, index 1 = source B, matching the sel encoding.
  logic [1:0] hb_in;
  logic [1:0] alive_w;

  assign hb_in = {hb_b, hb_a};

  // --------------------------------------------------------------------
  // Heartbeat synchroniser + watchdog, one per source
  // --------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hb
      logic            s1_q, s2_q, s3_q;
      logic            hb_edge;
      logic [WD_W-1:0] wd_q, wd_d;
      logic            alive_q, alive_d;

      // s1/s2 form the synchroniser; s3 is only the history bit for edges.
      assign hb_edge = s2_q ^ s3_q;

      always_comb begin
        wd_d    = wd_q;
        alive_d = alive_q;
        if (hb_edge) begin
          wd_d    = '0;
          alive_d = 1'b1;
        end else begin
          if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
          end
          // Health drops on the same edge the watchdog reaches TIMEOUT.
          if (wd_d == WD_MAX) begin
            alive_d = 1'b0;
          end
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          s1_q    <= 1'b0;
          s2_q    <= 1'b0;
          s3_q    <= 1'b0;
          wd_q    <= '0;
          alive_q <= 1'b0;
        end else begin
          s1_q    <= hb_in[gi];
          s2_q    <= s1_q;
          s3_q    <= s2_q;
          wd_q    <= wd_d;
          alive_q <= alive_d;
        end
      end

      assign alive_w[gi] = alive_q;
    end
  endgenerate

  assign alive_a = alive_w[0];
  assign alive_b = alive_w[1];

  // --------------------------------------------------------------------
  // Switch control FSM
  // --------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic            switching_q, switching_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            failover_q, failover_d;
  logic [ST_W-1:0] settle_q, settle_d;
  logic            fo_evt;
  logic            req_accept;

`ifdef CLK_SWITCH_AUTO_FAILOVER_EN
  // Level-based: health lost during SETTLE is acted on at the first IDLE
  // cycle. No switch when both sources are dead.
  assign fo_evt = (state_q == ST_IDLE) && !alive_w[sel_q] && alive_w[~sel_q];
`else
  assign fo_evt = 1'b0;
`endif

  // A failover owns the cycle, so a coincident request is held off.
  assign req_ready  = (state_q == ST_IDLE) && !fo_evt;
  assign req_accept = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    switching_d = switching_q;
    settle_d    = settle_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    failover_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fo_evt) begin
          sel_d       = ~sel_q;
          switching_d = 1'b1;
          settle_d    = ST_LOAD;
          state_d     = ST_SETTLE;
          failover_d  = 1'b1;
        end else if (req_accept) begin
          if (req_src == sel_q) begin
            done_d = 1'b1;
          end else if (!alive_w[req_src]) begin
            err_d = 1'b1;
          end else begin
            sel_d       = req_src;
            switching_d = 1'b1;
            settle_d    = ST_LOAD;
            state_d     = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        if (settle_q == '0) begin
          switching_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          settle_d = settle_q - ST_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      switching_q <= 1'b0;
      settle_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      failover_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      switching_q <= switching_d;
      settle_q    <= settle_d;
      done_q      <= done_d;
      err_q       <= err_d;
      failover_q  <= failover_d;
    end
  end

  assign sel       = sel_q;
  assign switching = switching_q;
  assign done      = done_q;
  assign err       = err_q;
  assign failover  = failover_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_switch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_clk_switch_ctrl                                            |
// | Purpose  : Randomised self-checking bench for clk_switch_ctrl. A         |
// |            timestamp-based reference model predicts every output each    |
// |            cycle. Honours CLK_SWITCH_AUTO_FAILOVER_EN when defined.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_clk_switch_ctrl;

  localparam int TIMEOUT = 64;
  localparam int SETTLE  = 16;
`ifdef CLK_SWITCH_AUTO_FAILOVER_EN
  localparam bit FO_EN = 1'b1;
`else
  localparam bit FO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic hb_a = 1'b0;
  logic hb_b = 1'b0;
  logic req_valid = 1'b0;
  logic req_src = 1'b0;
  logic req_ready, sel, switching, done, err, failover, alive_a, alive_b;

  clk_switch_ctrl #(
    .TIMEOUT(TIMEOUT),
    .SETTLE (SETTLE)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .hb_a     (hb_a),
    .hb_b     (hb_b),
    .req_valid(req_valid),
    .req_src  (req_src),
    .req_ready(req_ready),
    .sel      (sel),
    .switching(switching),
    .done     (done),
    .err      (err),
    .failover (failover),
    .alive_a  (alive_a),
    .alive_b  (alive_b)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cyc counts rising edges since start. A toggle driven in
  // cycle c makes the source healthy for edges c+3 .. c+3+TIMEOUT-1.
  // A switch decided in cycle T keeps the block busy until edge T+1+SETTLE.
  int cyc = 0;
  int m_busy_end = 0;
  bit m_sel = 1'b0;
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  bit m_fo = 1'b0;
  int tog_a[$];
  int tog_b[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_alive(input bit src, input int p);
    bit found;
    int c;
    found = 1'b0;
    c = 0;
    if (!src) begin
      for (int i = tog_a.size() - 1; i >= 0; i--)
        if (!found && (tog_a[i] + 3 <= p)) begin found = 1'b1; c = tog_a[i]; end
    end else begin
      for (int i = tog_b.size() - 1; i >= 0; i--)
        if (!found && (tog_b[i] + 3 <= p)) begin found = 1'b1; c = tog_b[i]; end
    end
    return found && ((p - (c + 3)) < TIMEOUT);
  endfunction

  function automatic bit m_fo_now();
    bit idle;
    idle = (cyc >= m_busy_end);
    return FO_EN && idle && !m_alive(m_sel, cyc) && m_alive(~m_sel, cyc);
  endfunction

  task automatic compare_all();
    bit idle;
    idle = (cyc >= m_busy_end);
    check_eq("sel", sel, m_sel);
    check_eq("switching", switching, cyc < m_busy_end);
    check_eq("done", done, m_done);
    check_eq("err", err, m_err);
    check_eq("failover", failover, m_fo);
    check_eq("alive_a", alive_a, m_alive(1'b0, cyc));
    check_eq("alive_b", alive_b, m_alive(1'b1, cyc));
    check_eq("req_ready", req_ready, idle && !m_fo_now());
  endtask

  // Drive one cycle of inputs (called just after a falling edge), update the
  // model for the next rising edge, then compare on the falling edge.
  task automatic tick(input bit v, input bit src, input bit ta, input bit tb);
    bit idle, fo;
    req_valid = v;
    req_src   = src;
    if (ta) begin
      hb_a = ~hb_a;
      tog_a.push_back(cyc);
      if (tog_a.size() > 8) void'(tog_a.pop_front());
    end
    if (tb) begin
      hb_b = ~hb_b;
      tog_b.push_back(cyc);
      if (tog_b.size() > 8) void'(tog_b.pop_front());
    end
    idle   = (cyc >= m_busy_end);
    fo     = m_fo_now();
    m_done = (cyc + 1 == m_busy_end);
    m_err  = 1'b0;
    m_fo   = 1'b0;
    if (fo) begin
      m_sel      = ~m_sel;
      m_busy_end = cyc + 1 + SETTLE;
      m_fo       = 1'b1;
    end else if (idle && v) begin
      if (src == m_sel) m_done = 1'b1;
      else if (!m_alive(src, cyc)) m_err = 1'b1;
      else begin
        m_sel      = src;
        m_busy_end = cyc + 1 + SETTLE;
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    compare_all();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    hb_a      = 1'b0;
    hb_b      = 1'b0;
    req_valid = 1'b0;
    #1;
    check_eq("rst_sel", sel, 0);
    check_eq("rst_switching", switching, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_failover", failover, 0);
    check_eq("rst_alive_a", alive_a, 0);
    check_eq("rst_alive_b", alive_b, 0);
    check_eq("rst_req_ready", req_ready, 1);
    tog_a.delete();
    tog_b.delete();
    m_sel      = 1'b0;
    m_done     = 1'b0;
    m_err      = 1'b0;
    m_fo       = 1'b0;
    m_busy_end = cyc;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    compare_all();
  endtask

  task automatic run_phase(input int n, input int per_a, input int per_b, input int req_pct);
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(99) < req_pct, 1'($urandom_range(1)),
           (per_a != 0) && (cyc % per_a == 0), (per_b != 0) && (cyc % per_b == 0));
    end
  endtask

  // Wait (bounded) for the model to be idle with both heartbeats running.
  task automatic go_idle();
    for (int i = 0; i < 200 && cyc < m_busy_end; i++)
      tick(1'b0, 1'b0, cyc % 4 == 0, cyc % 4 == 0);
    check_eq("idle_bound", cyc >= m_busy_end, 1);
  endtask

  initial begin
    #2;
    do_reset();
    // Both sources healthy, random requests.
    run_phase(300, 4, 4, 20);
    // Source B dead: requests to B rejected, failover if B selected.
    run_phase(200, 4, 0, 20);
    run_phase(200, 4, 4, 20);
    // Source A dead.
    run_phase(200, 0, 3, 20);
    // Both dead: sel must hold.
    run_phase(200, 0, 0, 20);
    run_phase(300, 1 + $urandom_range(6), 1 + $urandom_range(6), 30);

    // Target source loses health during the settle window, with a request
    // pending every cycle so the failover/request priority is exercised.
    run_phase(80, 4, 4, 0);
    go_idle();
    if (m_sel) begin
      run_phase(55, 0, 4, 0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      run_phase(40, 0, 4, 100);
    end else begin
      run_phase(55, 4, 0, 0);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      run_phase(40, 4, 0, 100);
    end

    // Reset in the middle of a settle window towards source B.
    run_phase(80, 4, 4, 0);
    go_idle();
    if (m_sel) begin
      tick(1'b1, 1'b0, cyc % 4 == 0, cyc % 4 == 0);
      go_idle();
    end
    tick(1'b1, 1'b1, cyc % 4 == 0, cyc % 4 == 0);
    check_eq("settle_sel_b", sel, 1);
    run_phase(4, 4, 4, 0);
    do_reset();
    run_phase(100, 4, 4, 0);

    run_phase(400, 1 + $urandom_range(8), 1 + $urandom_range(8), 25);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
